// File: rtl/instr_encoder.sv
// Streaming MIPS field-to-word encoder that loads instruction memory and
// holds the core in reset until the load ends. Optional: INSTR_ENCODER_CHECKSUM_EN.
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
`ifdef INSTR_ENCODER_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W:0]   wc_q;
  logic              we_q;
  logic              full_q;
  logic              err_q;
  logic [31:0]       enc_d;
  logic              legal_d;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [31:0]       csum_q;
`endif

  always_comb begin
    enc_d   = '0;
    legal_d = 1'b1;
    unique case (1'b1)
      op_sel == 4'd0: enc_d = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      op_sel == 4'd1: enc_d = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      op_sel == 4'd2: enc_d = {6'h00, rs, rt, rd, 5'd0, 6'h24};
      op_sel == 4'd3: enc_d = {6'h00, rs, rt, rd, 5'd0, 6'h25};
      op_sel == 4'd4: enc_d = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      op_sel == 4'd5: enc_d = {6'h23, rs, rt, imm};
      op_sel == 4'd6: enc_d = {6'h2B, rs, rt, imm};
      op_sel == 4'd7: enc_d = {6'h04, rs, rt, imm};
      op_sel == 4'd8: enc_d = {6'h08, rs, rt, imm};
      op_sel == 4'd9: enc_d = {6'h02, target};
      default:        legal_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wc_q    <= '0;
      we_q    <= 1'b0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= LOAD;
            addr_q  <= '0;
            wc_q    <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (legal_d) begin
              we_q    <= 1'b1;
              waddr_q <= addr_q;
              wdata_q <= enc_d;
              addr_q  <= addr_q + ADDR_W'(1);
              wc_q    <= wc_q + (ADDR_W+1)'(1);
`ifdef INSTR_ENCODER_CHECKSUM_EN
              csum_q  <= csum_q ^ enc_d;
`endif
              // Top address written: memory is full, end without in_last.
              if (addr_q == '1) begin
                full_q  <= 1'b1;
                state_q <= DONE;
              end
            end else begin
              err_q <= 1'b1;
            end
            if (in_last) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == LOAD);
  assign busy       = (state_q == LOAD);
  assign done       = (state_q == DONE);
  assign cpu_rst_n  = (state_q == DONE);
  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign full       = full_q;
  assign err        = err_q;
  assign word_count = wc_q;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  assign checksum   = csum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (64-word and 4-word) share stimulus
// and are checked every cycle against a behavioural load model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_last;
  logic [3:0]  op_sel;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;

  logic        a_rdy, a_we, a_crn, a_busy, a_done, a_full, a_err;
  logic [5:0]  a_addr;
  logic [31:0] a_wd;
  logic [6:0]  a_wc;
  logic        b_rdy, b_we, b_crn, b_busy, b_done, b_full, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wd;
  logic [2:0]  b_wc;
  logic [31:0] a_cs, b_cs;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(6)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(a_rdy), .in_last(in_last), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wd),
    .cpu_rst_n(a_crn), .busy(a_busy), .done(a_done), .full(a_full),
    .err(a_err),
`ifdef INSTR_ENCODER_CHECKSUM_EN
    .checksum(a_cs),
`endif
    .word_count(a_wc)
  );

  instr_encoder #(.ADDR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(b_rdy), .in_last(in_last), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wd),
    .cpu_rst_n(b_crn), .busy(b_busy), .done(b_done), .full(b_full),
    .err(b_err),
`ifdef INSTR_ENCODER_CHECKSUM_EN
    .checksum(b_cs),
`endif
    .word_count(b_wc)
  );

`ifndef INSTR_ENCODER_CHECKSUM_EN
  assign a_cs = '0;
  assign b_cs = '0;
`endif

  int total = 0;
  int bad   = 0;

  // Model state per instance: 0 = 64 words, 1 = 4 words.
  int          m_cap[2] = '{64, 4};
  bit          m_load[2], m_done[2], m_err[2], m_full[2], m_we[2];
  int          m_addr[2], m_wc[2], m_waddr[2];
  logic [31:0] m_wdata[2], m_cs[2];
  logic [31:0] mem_a[64];
  logic [31:0] mem_b[4];

  function automatic logic [32:0] encode(input logic [3:0] op);
    logic [31:0] r, i;
    r = 32'(rs) * 32'h200000 + 32'(rt) * 32'h10000 + 32'(rd) * 32'h800;
    i = 32'(rs) * 32'h200000 + 32'(rt) * 32'h10000 + 32'(imm);
    case (op)
      4'd0: return {1'b1, r + 32'h20};
      4'd1: return {1'b1, r + 32'h22};
      4'd2: return {1'b1, r + 32'h24};
      4'd3: return {1'b1, r + 32'h25};
      4'd4: return {1'b1, r + 32'h2A};
      4'd5: return {1'b1, 32'h23 * 32'h4000000 + i};
      4'd6: return {1'b1, 32'h2B * 32'h4000000 + i};
      4'd7: return {1'b1, 32'h04 * 32'h4000000 + i};
      4'd8: return {1'b1, 32'h08 * 32'h4000000 + i};
      4'd9: return {1'b1, 32'h02 * 32'h4000000 + 32'(target)};
      default: return 33'd0;
    endcase
  endfunction

  task automatic model_edge();
    logic [32:0] e;
    for (int k = 0; k < 2; k++) begin
      m_we[k] = 1'b0;
      if (!rst_n) begin
        m_load[k] = 0; m_done[k] = 0; m_err[k] = 0; m_full[k] = 0;
        m_addr[k] = 0; m_wc[k] = 0; m_cs[k] = 0;
      end else if (!m_load[k]) begin
        if (start) begin
          m_load[k] = 1; m_done[k] = 0; m_err[k] = 0; m_full[k] = 0;
          m_addr[k] = 0; m_wc[k] = 0; m_cs[k] = 0;
        end
      end else if (in_valid) begin
        e = encode(op_sel);
        if (e[32]) begin
          m_we[k] = 1'b1;
          m_waddr[k] = m_addr[k];
          m_wdata[k] = e[31:0];
          m_cs[k] = m_cs[k] ^ e[31:0];
          m_wc[k]++;
          if (m_addr[k] == m_cap[k] - 1) m_full[k] = 1;
          m_addr[k] = (m_addr[k] + 1) % m_cap[k];
        end else begin
          m_err[k] = 1;
        end
        if (in_last || m_full[k]) begin
          m_load[k] = 0;
          m_done[k] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input int k, input logic rdy, input logic we,
      input logic [5:0] ad, input logic [31:0] wd, input logic bs,
      input logic dn, input logic fl, input logic er, input logic crn,
      input logic [6:0] wc, input logic [31:0] cs);
    string p;
    p = (k == 0) ? "a." : "b.";
    chk({p, "in_ready"}, 32'(rdy), 32'(m_load[k]));
    chk({p, "busy"}, 32'(bs), 32'(m_load[k]));
    chk({p, "done"}, 32'(dn), 32'(m_done[k]));
    chk({p, "cpu_rst_n"}, 32'(crn), 32'(m_done[k]));
    chk({p, "full"}, 32'(fl), 32'(m_full[k]));
    chk({p, "err"}, 32'(er), 32'(m_err[k]));
    chk({p, "imem_we"}, 32'(we), 32'(m_we[k]));
    chk({p, "word_count"}, 32'(wc), 32'(m_wc[k]));
    if (m_we[k]) begin
      chk({p, "imem_addr"}, 32'(ad), 32'(m_waddr[k]));
      chk({p, "imem_wdata"}, wd, m_wdata[k]);
    end
`ifdef INSTR_ENCODER_CHECKSUM_EN
    chk({p, "checksum"}, cs, m_cs[k]);
`else
    if (cs !== 32'd0) chk({p, "checksum_tie"}, cs, 32'd0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_inst(0, a_rdy, a_we, a_addr, a_wd, a_busy, a_done, a_full, a_err,
             a_crn, a_wc, a_cs);
    chk_inst(1, b_rdy, b_we, 6'(b_addr), b_wd, b_busy, b_done, b_full,
             b_err, b_crn, 7'(b_wc), b_cs);
    if (a_we) mem_a[a_addr] = a_wd;
    if (b_we) mem_b[b_addr] = b_wd;
  endtask

  task automatic idle(input int n);
    start = 0; in_valid = 0; in_last = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic go();
    start = 1; step(); start = 0;
  endtask

  task automatic beat(input logic [3:0] op, input logic [4:0] s,
      input logic [4:0] t, input logic [4:0] d, input logic [15:0] im,
      input logic [25:0] tg, input logic last);
    op_sel = op; rs = s; rt = t; rd = d; imm = im; target = tg;
    in_last = last; in_valid = 1;
    step();
    in_valid = 0; in_last = 0;
  endtask

  initial begin
    rst_n = 0; start = 0; in_valid = 0; in_last = 0;
    op_sel = 0; rs = 0; rt = 0; rd = 0; imm = 0; target = 0;
    idle(2);
    chk("reset.a_cpu_rst_n", 32'(a_crn), 32'd0);
    rst_n = 1;
    idle(1);

    go();
    beat(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
    chk("t1.mem0", mem_a[0], 32'h00221820);
    chk("t1.done", 32'(a_done), 32'd1);
    beat(4'd0, 5'd9, 5'd9, 5'd9, 16'h0, 26'h0, 1'b1);
    chk("t1.no_write_in_done", 32'(a_we), 32'd0);
    idle(1);

    go();
    beat(4'd5, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0);
    start = 1;
    beat(4'd7, 5'd8, 5'd9, 5'd0, 16'hFFFF, 26'h0, 1'b0);
    start = 0;
    beat(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 1'b1);
    chk("t2.mem0", mem_a[0], 32'h8C080004);
    chk("t2.mem1", mem_a[1], 32'h1109FFFF);
    chk("t2.mem2", mem_a[2], 32'h08000010);
    chk("t2.wc", 32'(a_wc), 32'd3);
    idle(2);

    go();
    beat(4'd8, 5'd1, 5'd2, 5'd0, 16'h0005, 26'h0, 1'b0);
    beat(4'd12, 5'd1, 5'd1, 5'd1, 16'h1111, 26'h0, 1'b0);
    beat(4'd8, 5'd3, 5'd4, 5'd0, 16'h0007, 26'h0, 1'b1);
    chk("t3.mem0", mem_a[0], 32'h20220005);
    chk("t3.mem1", mem_a[1], 32'h20640007);
    chk("t3.err", 32'(a_err), 32'd1);
    chk("t3.wc", 32'(a_wc), 32'd2);
    idle(1);

    go();
    for (int i = 0; i < 4; i++)
      beat(4'd3, 5'd1, 5'd2, 5'(i + 4), 16'h0, 26'h0, 1'b0);
    chk("t4.b_ready_before_5th", 32'(b_rdy), 32'd0);
    chk("t4.b_full", 32'(b_full), 32'd1);
    chk("t4.b_done", 32'(b_done), 32'd1);
    beat(4'd3, 5'd1, 5'd2, 5'd8, 16'h0, 26'h0, 1'b0);
    chk("t4.b_mem3", mem_b[3], 32'h00223825);
    chk("t4.b_wc", 32'(b_wc), 32'd4);
    chk("t4.a_busy", 32'(a_busy), 32'd1);

    rst_n = 0; idle(1); rst_n = 1; idle(1);
    go();
    beat(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0);
    beat(4'd2, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0);
    rst_n = 0; idle(1);
    chk("t5.rst_busy", 32'(a_busy), 32'd0);
    chk("t5.rst_wc", 32'(a_wc), 32'd0);
    rst_n = 1; idle(1);
    go();
    beat(4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
    chk("t5.reload_mem0", mem_a[0], 32'h0022182A);
    idle(1);

    go();
    beat(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
    beat(4'd5, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b1);
    idle(1);
`ifdef INSTR_ENCODER_CHECKSUM_EN
    chk("t6.checksum", a_cs, 32'h8C2A1824);
`endif
    go();
`ifdef INSTR_ENCODER_CHECKSUM_EN
    chk("t6.checksum_clear", a_cs, 32'h0);
`endif
    beat(4'd6, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0, 1'b1);
    chk("t6.sw_mem0", mem_a[0], 32'hAC430010);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
